// File: rtl/seven_segment_scan_reader.sv
// ============================================================================
// seven_segment_scan_reader
// Decodes a multiplexed 4-digit seven-segment bus back into a 16-bit word.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seven_segment_scan_reader #(
    parameter int SETTLE_CYCLES = 2,
    parameter int SCAN_TIMEOUT  = 1024
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [6:0]  light_segment,
    input  logic [3:0]  digit_enable,
    output logic [15:0] word_value,
    output logic        word_valid,
    output logic        word_error,
    output logic        frame_abort
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SETTLE   = 2'd1,
        S_WAIT     = 2'd2,
        S_COMPLETE = 2'd3
    } state_t;

    localparam logic [3:0]  c_SETTLE      = 4'(SETTLE_CYCLES);
    localparam logic [15:0] c_TIMEOUT     = 16'(SCAN_TIMEOUT);
    localparam bit          c_SETTLE_ZERO = (SETTLE_CYCLES == 0);

    // Returns {pattern_is_legal, nibble}; illegal patterns decode to 0.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h3F:   r = 5'h10;
            7'h06:   r = 5'h11;
            7'h5B:   r = 5'h12;
            7'h4F:   r = 5'h13;
            7'h66:   r = 5'h14;
            7'h6D:   r = 5'h15;
            7'h7D:   r = 5'h16;
            7'h07:   r = 5'h17;
            7'h7F:   r = 5'h18;
            7'h6F:   r = 5'h19;
            7'h77:   r = 5'h1A;
            7'h7C:   r = 5'h1B;
            7'h39:   r = 5'h1C;
            7'h5E:   r = 5'h1D;
            7'h79:   r = 5'h1E;
            7'h71:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  enable_prev_q;
    logic [1:0]  expect_q, expect_d;
    logic [3:0]  settle_cnt_q, settle_cnt_d;
    logic [15:0] timeout_cnt_q, timeout_cnt_d;
    logic [15:0] frame_q, frame_d;
    logic        err_q, err_d;
    logic [15:0] word_value_q, word_value_d;
    logic        word_valid_q, word_valid_d;
    logic        word_error_q, word_error_d;
    logic        frame_abort_q, frame_abort_d;

    logic        w_seg_ok;
    logic [3:0]  w_seg_nib;
    logic        w_onehot;
    logic        w_multi;
    logic        w_changed;
    logic        w_event;
    logic [1:0]  w_digit;
    logic        w_abort;
    logic        w_start0;
    logic        w_cap;
    logic [1:0]  w_cap_digit;

    assign {w_seg_ok, w_seg_nib} = decode_seg(light_segment);

    assign w_onehot  = (digit_enable != 4'b0000) &&
                       ((digit_enable & (digit_enable - 4'd1)) == 4'b0000);
    assign w_multi   = (digit_enable != 4'b0000) && !w_onehot;
    assign w_changed = (digit_enable != enable_prev_q);
    assign w_event   = w_onehot && w_changed;

    always_comb begin
        w_digit = 2'd0;
        case (digit_enable)
            4'b0010: w_digit = 2'd1;
            4'b0100: w_digit = 2'd2;
            4'b1000: w_digit = 2'd3;
            default: w_digit = 2'd0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        expect_d      = expect_q;
        settle_cnt_d  = settle_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        frame_d       = frame_q;
        err_d         = err_q;
        word_value_d  = word_value_q;
        word_valid_d  = 1'b0;
        word_error_d  = 1'b0;
        frame_abort_d = 1'b0;
        w_abort       = 1'b0;
        w_start0      = 1'b0;
        w_cap         = 1'b0;
        w_cap_digit   = expect_q;

        case (state_q)
            S_IDLE, S_COMPLETE: begin
                state_d = S_IDLE;
                if (w_event && (w_digit == 2'd0)) w_start0 = 1'b1;
            end
            S_SETTLE: begin
                if (w_changed) begin
                    w_abort = 1'b1;
                    if (w_event && (w_digit == 2'd0)) w_start0 = 1'b1;
                end else if (settle_cnt_q == c_SETTLE) begin
                    w_cap = 1'b1;
                end else begin
                    settle_cnt_d = settle_cnt_q + 4'd1;
                end
            end
            S_WAIT: begin
                if (w_multi) begin
                    w_abort = 1'b1;
                end else if (w_event) begin
                    if (w_digit == expect_q) begin
                        if (c_SETTLE_ZERO) begin
                            w_cap = 1'b1;
                        end else begin
                            state_d      = S_SETTLE;
                            settle_cnt_d = 4'd1;
                        end
                    end else begin
                        w_abort = 1'b1;
                        if (w_digit == 2'd0) w_start0 = 1'b1;
                    end
                end else if (timeout_cnt_q == c_TIMEOUT) begin
                    w_abort = 1'b1;
                end else begin
                    timeout_cnt_d = timeout_cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w_abort) begin
            frame_abort_d = 1'b1;
            frame_d       = 16'h0000;
            err_d         = 1'b0;
            state_d       = S_IDLE;
        end

        // A digit-0 event restarts the frame even when it also aborted one.
        if (w_start0) begin
            expect_d = 2'd0;
            frame_d  = 16'h0000;
            err_d    = 1'b0;
            if (c_SETTLE_ZERO) begin
                w_cap       = 1'b1;
                w_cap_digit = 2'd0;
            end else begin
                state_d      = S_SETTLE;
                settle_cnt_d = 4'd1;
            end
        end

        if (w_cap) begin
            frame_d[{w_cap_digit, 2'b00} +: 4] = w_seg_nib;
            err_d = err_d | ~w_seg_ok;
            if (w_cap_digit == 2'd3) begin
                word_value_d = frame_d;
                word_valid_d = 1'b1;
                word_error_d = err_d;
                frame_d      = 16'h0000;
                err_d        = 1'b0;
                state_d      = S_COMPLETE;
            end else begin
                expect_d      = w_cap_digit + 2'd1;
                timeout_cnt_d = 16'd1;
                state_d       = S_WAIT;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            enable_prev_q <= 4'b0000;
            expect_q      <= 2'd0;
            settle_cnt_q  <= 4'd0;
            timeout_cnt_q <= 16'd0;
            frame_q       <= 16'h0000;
            err_q         <= 1'b0;
            word_value_q  <= 16'h0000;
            word_valid_q  <= 1'b0;
            word_error_q  <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            enable_prev_q <= digit_enable;
            expect_q      <= expect_d;
            settle_cnt_q  <= settle_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            frame_q       <= frame_d;
            err_q         <= err_d;
            word_value_q  <= word_value_d;
            word_valid_q  <= word_valid_d;
            word_error_q  <= word_error_d;
            frame_abort_q <= frame_abort_d;
        end
    end

    assign word_value  = word_value_q;
    assign word_valid  = word_valid_q;
    assign word_error  = word_error_q;
    assign frame_abort = frame_abort_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_segment_scan_reader.sv
// ============================================================================
// tb_seven_segment_scan_reader
// Directed-vector bench for the seven-segment scan reader.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seven_segment_scan_reader;

    logic        clock;
    logic        reset_n;
    logic [6:0]  light_segment;
    logic [3:0]  digit_enable;
    logic [15:0] word_value;
    logic        word_valid;
    logic        word_error;
    logic        frame_abort;

    int checks;
    int errors;
    int n_valid;
    int n_error;
    int n_abort;
    int n_err_alone;

    seven_segment_scan_reader #(
        .SETTLE_CYCLES(2),
        .SCAN_TIMEOUT (16)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .light_segment(light_segment),
        .digit_enable (digit_enable),
        .word_value   (word_value),
        .word_valid   (word_valid),
        .word_error   (word_error),
        .frame_abort  (frame_abort)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (word_valid) n_valid++;
        if (word_error) n_error++;
        if (frame_abort) n_abort++;
        if (word_error && !word_valid) n_err_alone++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic show(input int d, input logic [6:0] seg, input int hold);
        digit_enable  = 4'b0001 << d;
        light_segment = seg;
        step(hold);
    endtask

    task automatic blank();
        digit_enable = 4'b0000;
        step(2);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        digit_enable = 4'b0000;
        light_segment = 7'h00;
        step(3);
        checks++;
        if (word_value !== 16'h0000) begin
            errors++; $display("FAIL reset_value actual=%h required=0000", word_value);
        end
        checks++;
        if ({word_valid, word_error, frame_abort} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses actual=%b required=000",
                               {word_valid, word_error, frame_abort});
        end
        reset_n = 1'b1;
        step(2);
    endtask

    task automatic test_clean();
        int v0;
        v0 = n_valid;
        show(0, 7'h06, 8);
        show(1, 7'h5B, 8);
        show(2, 7'h4F, 8);
        digit_enable  = 4'b1000;
        light_segment = 7'h66;
        step(2);
        checks++;
        if (word_valid !== 1'b0) begin
            errors++; $display("FAIL clean_early_valid actual=%b required=0", word_valid);
        end
        step(1);
        checks++;
        if (word_valid !== 1'b1) begin
            errors++; $display("FAIL clean_valid_timing actual=%b required=1", word_valid);
        end
        checks++;
        if (word_value !== 16'h4321) begin
            errors++; $display("FAIL clean_value actual=%h required=4321", word_value);
        end
        checks++;
        if (word_error !== 1'b0) begin
            errors++; $display("FAIL clean_error actual=%b required=0", word_error);
        end
        step(5);
        blank();
        checks++;
        if (n_valid - v0 !== 1) begin
            errors++; $display("FAIL clean_valid_count actual=%0d required=1", n_valid - v0);
        end
    endtask

    task automatic test_invalid();
        int v0, e0;
        v0 = n_valid;
        e0 = n_error;
        show(0, 7'h71, 8);
        show(1, 7'h79, 8);
        show(2, 7'h00, 8);
        show(3, 7'h77, 8);
        blank();
        checks++;
        if (word_value !== 16'hA0EF) begin
            errors++; $display("FAIL invalid_value actual=%h required=a0ef", word_value);
        end
        checks++;
        if ((n_valid - v0 !== 1) || (n_error - e0 !== 1) || (n_err_alone !== 0)) begin
            errors++; $display("FAIL invalid_pulses actual=valid%0d/err%0d/alone%0d required=1/1/0",
                               n_valid - v0, n_error - e0, n_err_alone);
        end
    endtask

    task automatic test_settle_glitch();
        int v0, a0, e0;
        v0 = n_valid;
        a0 = n_abort;
        show(0, 7'h06, 8);
        digit_enable  = 4'b0010;
        light_segment = 7'h5B;
        step(1);
        digit_enable = 4'b0000;
        step(1);
        checks++;
        if (frame_abort !== 1'b1) begin
            errors++; $display("FAIL glitch_abort actual=%b required=1", frame_abort);
        end
        step(4);
        checks++;
        if ((n_valid - v0 !== 0) || (n_abort - a0 !== 1) || (word_value !== 16'hA0EF)) begin
            errors++; $display("FAIL glitch_outcome actual=valid%0d/abort%0d/%h required=0/1/a0ef",
                               n_valid - v0, n_abort - a0, word_value);
        end
        e0 = n_error;
        show(0, 7'h06, 8);
        show(1, 7'h5B, 8);
        show(2, 7'h4F, 8);
        show(3, 7'h66, 8);
        blank();
        checks++;
        if ((word_value !== 16'h4321) || (n_error - e0 !== 0)) begin
            errors++; $display("FAIL glitch_recover actual=%h/err%0d required=4321/0",
                               word_value, n_error - e0);
        end
    endtask

    task automatic test_order_restart();
        int v0, a0;
        v0 = n_valid;
        a0 = n_abort;
        show(0, 7'h3F, 8);
        digit_enable  = 4'b0100;
        light_segment = 7'h5B;
        step(1);
        checks++;
        if (frame_abort !== 1'b1) begin
            errors++; $display("FAIL order_abort actual=%b required=1", frame_abort);
        end
        show(0, 7'h3F, 8);
        show(1, 7'h06, 8);
        show(2, 7'h5B, 8);
        show(3, 7'h4F, 8);
        blank();
        checks++;
        if ((word_value !== 16'h3210) || (n_valid - v0 !== 1) || (n_abort - a0 !== 1)) begin
            errors++; $display("FAIL order_restart actual=%h/valid%0d/abort%0d required=3210/1/1",
                               word_value, n_valid - v0, n_abort - a0);
        end
        v0 = n_valid;
        a0 = n_abort;
        show(0, 7'h3F, 8);
        show(1, 7'h06, 8);
        digit_enable  = 4'b0001;
        light_segment = 7'h7D;
        step(1);
        checks++;
        if (frame_abort !== 1'b1) begin
            errors++; $display("FAIL wait_restart_abort actual=%b required=1", frame_abort);
        end
        step(7);
        show(1, 7'h07, 8);
        show(2, 7'h7F, 8);
        show(3, 7'h6F, 8);
        blank();
        checks++;
        if ((word_value !== 16'h9876) || (n_valid - v0 !== 1) || (n_abort - a0 !== 1)) begin
            errors++; $display("FAIL wait_restart actual=%h/valid%0d/abort%0d required=9876/1/1",
                               word_value, n_valid - v0, n_abort - a0);
        end
    endtask

    task automatic test_timeout_multihot();
        int a0;
        show(0, 7'h06, 8);
        digit_enable  = 4'b0010;
        light_segment = 7'h5B;
        step(3);
        digit_enable = 4'b0000;
        a0 = n_abort;
        step(15);
        checks++;
        if ((frame_abort !== 1'b0) || (n_abort - a0 !== 0)) begin
            errors++; $display("FAIL timeout_early actual=%b/%0d required=0/0",
                               frame_abort, n_abort - a0);
        end
        step(1);
        checks++;
        if (frame_abort !== 1'b1) begin
            errors++; $display("FAIL timeout_exact actual=%b required=1", frame_abort);
        end
        step(2);
        checks++;
        if (word_value !== 16'h9876) begin
            errors++; $display("FAIL timeout_hold actual=%h required=9876", word_value);
        end
        show(0, 7'h06, 8);
        digit_enable = 4'b0011;
        step(1);
        checks++;
        if (frame_abort !== 1'b1) begin
            errors++; $display("FAIL multihot_abort actual=%b required=1", frame_abort);
        end
        blank();
    endtask

    task automatic test_reset_midframe();
        int a0;
        show(0, 7'h06, 8);
        show(1, 7'h5B, 4);
        a0 = n_abort;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({word_value, word_valid, word_error, frame_abort} !== 19'h0) begin
            errors++; $display("FAIL midreset_outputs actual=%h/%b%b%b required=0000/000",
                               word_value, word_valid, word_error, frame_abort);
        end
        step(2);
        digit_enable = 4'b0000;
        reset_n = 1'b1;
        step(2);
        checks++;
        if (n_abort - a0 !== 0) begin
            errors++; $display("FAIL midreset_no_abort actual=%0d required=0", n_abort - a0);
        end
        show(0, 7'h7F, 8);
        show(1, 7'h7F, 8);
        show(2, 7'h7F, 8);
        show(3, 7'h7F, 8);
        blank();
        checks++;
        if (word_value !== 16'h8888) begin
            errors++; $display("FAIL midreset_frame actual=%h required=8888", word_value);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        n_valid = 0;
        n_error = 0;
        n_abort = 0;
        n_err_alone = 0;
        test_reset();
        test_clean();
        test_invalid();
        test_settle_glitch();
        test_order_restart();
        test_timeout_multihot();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
